// File: rtl/instruction_decode.sv
`default_nettype none
// ============================================================================
// Module   : instruction_decode
// Purpose  : Decode stage of the RV32IM pipeline. The stage takes the
//            IF/ID instruction and its PC/PC+4, reads the 32x32 register
//            file, generates the control signals and the sign-extended
//            immediate, and latches the results into the ID/EX register.
//            The stage also owns the register-file write port, which is
//            driven by the writeback bus.
// Ports    :
//   CLK, RESET               clock / synchronous active-high reset
//   instruction_in           instruction from IF/ID
//   pc_in, pc4_in            PC and PC+4 of that instruction
//   write_data_in            writeback data
//   write_reg_in             writeback destination register
//   reg_write_enable_in      writeback enable
//   stall                    hold the ID/EX contents
//   flush                    load a bubble (all zeros) into ID/EX
//   *_out / *_sel            registered ID/EX fields consumed by execute
// Revision : 1.0 - initial release
// ============================================================================
module instruction_decode (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] instruction_in,
    input  logic [31:0] pc_in,
    input  logic [31:0] pc4_in,
    input  logic [31:0] write_data_in,
    input  logic [4:0]  write_reg_in,
    input  logic        reg_write_enable_in,
    input  logic        stall,
    input  logic        flush,
    output logic [31:0] pc_out,
    output logic [31:0] pc4_out,
    output logic [31:0] data1_out,
    output logic [31:0] data2_out,
    output logic [31:0] imm_out,
    output logic [4:0]  rs1_out,
    output logic [4:0]  rs2_out,
    output logic [4:0]  rd_out,
    output logic [2:0]  funct3_out,
    output logic [4:0]  alu_op_out,
    output logic        alu_src1_sel,
    output logic [1:0]  alu_src2_sel,
    output logic        mem_read_out,
    output logic        mem_write_out,
    output logic        mux3_select_out,
    output logic        reg_write_enable_out,
    output logic        branch_out,
    output logic        jump_out,
    output logic        illegal_out
);

    // ------------------------------------------------------------------
    // Opcodes
    // ------------------------------------------------------------------
    localparam logic [6:0] c_OP_REG    = 7'b0110011;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;

    // funct7 values accepted on R-type encodings
    localparam logic [6:0] c_F7_BASE   = 7'b0000000;
    localparam logic [6:0] c_F7_ALT    = 7'b0100000;
    localparam logic [6:0] c_F7_MULDIV = 7'b0000001;

    // ------------------------------------------------------------------
    // ALU operation codes
    // ------------------------------------------------------------------
    localparam logic [4:0] c_ALU_ADD    = 5'd0;
    localparam logic [4:0] c_ALU_SUB    = 5'd1;
    localparam logic [4:0] c_ALU_SLL    = 5'd2;
    localparam logic [4:0] c_ALU_SLT    = 5'd3;
    localparam logic [4:0] c_ALU_SLTU   = 5'd4;
    localparam logic [4:0] c_ALU_XOR    = 5'd5;
    localparam logic [4:0] c_ALU_SRL    = 5'd6;
    localparam logic [4:0] c_ALU_SRA    = 5'd7;
    localparam logic [4:0] c_ALU_OR     = 5'd8;
    localparam logic [4:0] c_ALU_AND    = 5'd9;
    localparam logic [4:0] c_ALU_MUL    = 5'd10;
    localparam logic [4:0] c_ALU_PASS_B = 5'd18;

    // ALU second-operand select encoding
    localparam logic [1:0] c_SRC2_RS2  = 2'd0;
    localparam logic [1:0] c_SRC2_IMM  = 2'd1;
    localparam logic [1:0] c_SRC2_FOUR = 2'd2;

    // ------------------------------------------------------------------
    // Instruction fields
    // ------------------------------------------------------------------
    logic [6:0] w_opcode;
    logic [4:0] w_rd;
    logic [2:0] w_funct3;
    logic [4:0] w_rs1;
    logic [4:0] w_rs2;
    logic [6:0] w_funct7;

    assign w_opcode = instruction_in[6:0];
    assign w_rd     = instruction_in[11:7];
    assign w_funct3 = instruction_in[14:12];
    assign w_rs1    = instruction_in[19:15];
    assign w_rs2    = instruction_in[24:20];
    assign w_funct7 = instruction_in[31:25];

    // ------------------------------------------------------------------
    // Register file: x0 is never written, and reads of x0 are forced to 0
    // as well so the rule holds even across the reset edge.
    // ------------------------------------------------------------------
    logic [31:0] r_regs [32];
    logic        w_wb_active;
    logic [31:0] w_rs1_data;
    logic [31:0] w_rs2_data;

    assign w_wb_active = reg_write_enable_in && (write_reg_in != 5'd0);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            // A writeback arriving together with RESET is dropped.
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wb_active) begin
            r_regs[write_reg_in] <= write_data_in;
        end
    end

    // Write-first bypass: a read of the register being written this cycle
    // returns the incoming data rather than the stale array contents.
    always_comb begin
        if (w_rs1 == 5'd0) begin
            w_rs1_data = '0;
        end else if (w_wb_active && (write_reg_in == w_rs1)) begin
            w_rs1_data = write_data_in;
        end else begin
            w_rs1_data = r_regs[w_rs1];
        end
    end

    always_comb begin
        if (w_rs2 == 5'd0) begin
            w_rs2_data = '0;
        end else if (w_wb_active && (write_reg_in == w_rs2)) begin
            w_rs2_data = write_data_in;
        end else begin
            w_rs2_data = r_regs[w_rs2];
        end
    end

    // ------------------------------------------------------------------
    // Immediate formats
    // ------------------------------------------------------------------
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_j;

    assign w_imm_i = {{20{instruction_in[31]}}, instruction_in[31:20]};
    assign w_imm_s = {{20{instruction_in[31]}}, instruction_in[31:25],
                      instruction_in[11:7]};
    assign w_imm_b = {{19{instruction_in[31]}}, instruction_in[31],
                      instruction_in[7], instruction_in[30:25],
                      instruction_in[11:8], 1'b0};
    assign w_imm_u = {instruction_in[31:12], 12'b0};
    assign w_imm_j = {{11{instruction_in[31]}}, instruction_in[31],
                      instruction_in[19:12], instruction_in[20],
                      instruction_in[30:21], 1'b0};

    // ------------------------------------------------------------------
    // funct3 -> base integer ALU op (before the SUB/SRA alternates)
    // ------------------------------------------------------------------
    logic [4:0] w_base_op;

    always_comb begin
        w_base_op = c_ALU_ADD;
        case (w_funct3)
            3'd0:    w_base_op = c_ALU_ADD;
            3'd1:    w_base_op = c_ALU_SLL;
            3'd2:    w_base_op = c_ALU_SLT;
            3'd3:    w_base_op = c_ALU_SLTU;
            3'd4:    w_base_op = c_ALU_XOR;
            3'd5:    w_base_op = c_ALU_SRL;
            3'd6:    w_base_op = c_ALU_OR;
            default: w_base_op = c_ALU_AND;
        endcase
    end

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    logic [31:0] w_imm;
    logic [4:0]  w_alu_op;
    logic        w_src1_pc;
    logic [1:0]  w_src2;
    logic        w_mem_read;
    logic        w_mem_write;
    logic        w_mux3;
    logic        w_reg_write;
    logic        w_branch;
    logic        w_jump;
    logic        w_illegal;

    always_comb begin
        w_imm       = '0;
        w_alu_op    = c_ALU_ADD;
        w_src1_pc   = 1'b0;
        w_src2      = c_SRC2_RS2;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_mux3      = 1'b0;
        w_reg_write = 1'b0;
        w_branch    = 1'b0;
        w_jump      = 1'b0;
        w_illegal   = 1'b0;

        case (w_opcode)
            c_OP_REG: begin
                if (w_funct7 == c_F7_MULDIV) begin
                    // M-extension ops are laid out contiguously by funct3.
                    w_alu_op    = c_ALU_MUL + {2'b00, w_funct3};
                    w_reg_write = 1'b1;
                end else if ((w_funct7 == c_F7_BASE) ||
                             (w_funct7 == c_F7_ALT)) begin
                    w_alu_op = w_base_op;
                    if (w_funct7[5] && (w_funct3 == 3'd0)) begin
                        w_alu_op = c_ALU_SUB;
                    end else if (w_funct7[5] && (w_funct3 == 3'd5)) begin
                        w_alu_op = c_ALU_SRA;
                    end
                    w_reg_write = 1'b1;
                end else begin
                    w_illegal = 1'b1;
                end
            end
            c_OP_IMM: begin
                // funct3=0 is always ADDI; only shifts honour funct7[5].
                w_alu_op = w_base_op;
                if (w_funct7[5] && (w_funct3 == 3'd5)) begin
                    w_alu_op = c_ALU_SRA;
                end
                w_imm       = w_imm_i;
                w_src2      = c_SRC2_IMM;
                w_reg_write = 1'b1;
            end
            c_OP_LOAD: begin
                w_imm       = w_imm_i;
                w_src2      = c_SRC2_IMM;
                w_mem_read  = 1'b1;
                w_mux3      = 1'b1;
                w_reg_write = 1'b1;
            end
            c_OP_STORE: begin
                w_imm       = w_imm_s;
                w_src2      = c_SRC2_IMM;
                w_mem_write = 1'b1;
            end
            c_OP_BRANCH: begin
                w_imm    = w_imm_b;
                w_alu_op = c_ALU_SUB;
                w_branch = 1'b1;
            end
            c_OP_JAL: begin
                // The ALU computes the link address PC+4.
                w_imm       = w_imm_j;
                w_src1_pc   = 1'b1;
                w_src2      = c_SRC2_FOUR;
                w_jump      = 1'b1;
                w_reg_write = 1'b1;
            end
            c_OP_JALR: begin
                // Link address from the ALU; target is data1+imm in execute.
                w_imm       = w_imm_i;
                w_src1_pc   = 1'b1;
                w_src2      = c_SRC2_FOUR;
                w_jump      = 1'b1;
                w_reg_write = 1'b1;
            end
            c_OP_LUI: begin
                w_imm       = w_imm_u;
                w_alu_op    = c_ALU_PASS_B;
                w_src2      = c_SRC2_IMM;
                w_reg_write = 1'b1;
            end
            c_OP_AUIPC: begin
                w_imm       = w_imm_u;
                w_src1_pc   = 1'b1;
                w_src2      = c_SRC2_IMM;
                w_reg_write = 1'b1;
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // ID/EX register. RESET and flush both load all zeros; stall holds.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET || flush) begin
            pc_out               <= '0;
            pc4_out              <= '0;
            data1_out            <= '0;
            data2_out            <= '0;
            imm_out              <= '0;
            rs1_out              <= '0;
            rs2_out              <= '0;
            rd_out               <= '0;
            funct3_out           <= '0;
            alu_op_out           <= '0;
            alu_src1_sel         <= 1'b0;
            alu_src2_sel         <= '0;
            mem_read_out         <= 1'b0;
            mem_write_out        <= 1'b0;
            mux3_select_out      <= 1'b0;
            reg_write_enable_out <= 1'b0;
            branch_out           <= 1'b0;
            jump_out             <= 1'b0;
            illegal_out          <= 1'b0;
        end else if (!stall) begin
            pc_out               <= pc_in;
            pc4_out              <= pc4_in;
            data1_out            <= w_rs1_data;
            data2_out            <= w_rs2_data;
            imm_out              <= w_imm;
            rs1_out              <= w_rs1;
            rs2_out              <= w_rs2;
            rd_out               <= w_rd;
            funct3_out           <= w_funct3;
            alu_op_out           <= w_alu_op;
            alu_src1_sel         <= w_src1_pc;
            alu_src2_sel         <= w_src2;
            mem_read_out         <= w_mem_read;
            mem_write_out        <= w_mem_write;
            mux3_select_out      <= w_mux3;
            reg_write_enable_out <= w_reg_write;
            branch_out           <= w_branch;
            jump_out             <= w_jump;
            illegal_out          <= w_illegal;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instruction_decode.sv
`default_nettype none
// ============================================================================
// Module   : tb_instruction_decode
// Purpose  : Self-checking bench for instruction_decode. A register array
//            and an opcode-table decoder model the expected ID/EX contents
//            for directed instructions and for randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_decode;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [4:0]  alu;
        logic        s1;
        logic [1:0]  s2;
        logic        mr;
        logic        mw;
        logic        mux;
        logic        rw;
        logic        br;
        logic        jmp;
        logic        ill;
    } idex_t;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] instruction_in, pc_in, pc4_in, write_data_in;
    logic [4:0]  write_reg_in;
    logic        reg_write_enable_in, stall, flush;
    logic [31:0] pc_out, pc4_out, data1_out, data2_out, imm_out;
    logic [4:0]  rs1_out, rs2_out, rd_out, alu_op_out;
    logic [2:0]  funct3_out;
    logic        alu_src1_sel;
    logic [1:0]  alu_src2_sel;
    logic        mem_read_out, mem_write_out, mux3_select_out;
    logic        reg_write_enable_out, branch_out, jump_out, illegal_out;

    always #5 CLK = ~CLK;

    instruction_decode dut (
        .CLK                  (CLK),
        .RESET                (RESET),
        .instruction_in       (instruction_in),
        .pc_in                (pc_in),
        .pc4_in               (pc4_in),
        .write_data_in        (write_data_in),
        .write_reg_in         (write_reg_in),
        .reg_write_enable_in  (reg_write_enable_in),
        .stall                (stall),
        .flush                (flush),
        .pc_out               (pc_out),
        .pc4_out              (pc4_out),
        .data1_out            (data1_out),
        .data2_out            (data2_out),
        .imm_out              (imm_out),
        .rs1_out              (rs1_out),
        .rs2_out              (rs2_out),
        .rd_out               (rd_out),
        .funct3_out           (funct3_out),
        .alu_op_out           (alu_op_out),
        .alu_src1_sel         (alu_src1_sel),
        .alu_src2_sel         (alu_src2_sel),
        .mem_read_out         (mem_read_out),
        .mem_write_out        (mem_write_out),
        .mux3_select_out      (mux3_select_out),
        .reg_write_enable_out (reg_write_enable_out),
        .branch_out           (branch_out),
        .jump_out             (jump_out),
        .illegal_out          (illegal_out)
    );

    idex_t act;
    assign act = {pc_out, pc4_out, data1_out, data2_out, imm_out, rs1_out,
                  rs2_out, rd_out, funct3_out, alu_op_out, alu_src1_sel,
                  alu_src2_sel, mem_read_out, mem_write_out, mux3_select_out,
                  reg_write_enable_out, branch_out, jump_out, illegal_out};

    // Reference state
    logic [31:0] mregs [32];
    idex_t       exp_q;
    logic [31:0] cur_pc;
    int          n_checks = 0;
    int          n_fail   = 0;

    // ALU code of each funct3 for the base integer ops (no SUB/SRA)
    logic [4:0] base_op [8] = '{5'd0, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd8, 5'd9};
    logic [6:0] valid_ops [9] = '{7'b0110011, 7'b0010011, 7'b0000011,
                                  7'b0100011, 7'b1100011, 7'b1101111,
                                  7'b1100111, 7'b0110111, 7'b0010111};

    // Expected ID/EX contents for one instruction given its operand values
    function automatic idex_t model(input logic [31:0] ins, input logic [31:0] pc,
                                    input logic [31:0] d1, input logic [31:0] d2);
        idex_t e;
        logic signed [31:0] s;
        logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
        logic [2:0]  f3;
        logic [6:0]  f7;
        e = '0;
        s = ins;
        f3 = ins[14:12];
        f7 = ins[31:25];
        imm_i = s >>> 20;
        imm_s = {imm_i[31:5], ins[11:7]};
        imm_b = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
        imm_u = {ins[31:12], 12'h000};
        imm_j = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
        e.pc = pc; e.pc4 = pc + 32'd4; e.d1 = d1; e.d2 = d2;
        e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7]; e.f3 = f3;
        case (ins[6:0])
            7'b0110011: begin
                if (f7 == 7'h01) begin
                    e.alu = 5'(10 + int'(f3)); e.rw = 1;
                end else if (f7 == 7'h00 || f7 == 7'h20) begin
                    e.alu = (f7 == 7'h20 && f3 == 3'd0) ? 5'd1 :
                            (f7 == 7'h20 && f3 == 3'd5) ? 5'd7 : base_op[f3];
                    e.rw = 1;
                end else begin
                    e.ill = 1;
                end
            end
            7'b0010011: begin
                e.alu = (f7[5] && f3 == 3'd5) ? 5'd7 : base_op[f3];
                e.imm = imm_i; e.s2 = 2'd1; e.rw = 1;
            end
            7'b0000011: begin e.imm = imm_i; e.s2 = 2'd1; e.mr = 1; e.mux = 1; e.rw = 1; end
            7'b0100011: begin e.imm = imm_s; e.s2 = 2'd1; e.mw = 1; end
            7'b1100011: begin e.imm = imm_b; e.alu = 5'd1; e.br = 1; end
            7'b1101111: begin e.imm = imm_j; e.s1 = 1; e.s2 = 2'd2; e.jmp = 1; e.rw = 1; end
            7'b1100111: begin e.imm = imm_i; e.s1 = 1; e.s2 = 2'd2; e.jmp = 1; e.rw = 1; end
            7'b0110111: begin e.imm = imm_u; e.alu = 5'd18; e.s2 = 2'd1; e.rw = 1; end
            7'b0010111: begin e.imm = imm_u; e.s1 = 1; e.s2 = 2'd1; e.rw = 1; end
            default:    e.ill = 1;
        endcase
        return e;
    endfunction

    task automatic check_all(input string tag);
        n_checks++;
        assert (act === exp_q) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, act, exp_q);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_checks++;
        assert (obs === req) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, req);
        end
    endtask

    // Apply one cycle of inputs, advance the model, and compare after the edge
    task automatic step(input string tag, input logic [31:0] ins, input logic st,
                        input logic fl, input logic rs, input logic we,
                        input logic [4:0] wr, input logic [31:0] wd);
        instruction_in      = ins;
        pc_in               = cur_pc;
        pc4_in              = cur_pc + 32'd4;
        stall               = st;
        flush               = fl;
        RESET               = rs;
        reg_write_enable_in = we;
        write_reg_in        = wr;
        write_data_in       = wd;
        if (rs) begin
            for (int i = 0; i < 32; i++) mregs[i] = '0;
            exp_q = '0;
        end else begin
            // Applying the write first gives the write-first read result.
            if (we && wr != 5'd0) mregs[wr] = wd;
            if (fl) exp_q = '0;
            else if (!st) exp_q = model(ins, cur_pc, mregs[ins[19:15]], mregs[ins[24:20]]);
        end
        cur_pc = cur_pc + 32'd4;
        @(posedge CLK);
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [31:0] ins;
        logic [4:0]  wr;
        for (int i = 0; i < 32; i++) mregs[i] = '0;
        exp_q  = '0;
        cur_pc = 32'h0000_1000;

        // Reset, then write x5 and read it back
        step("reset", 32'h0000_0013, 0, 0, 1, 0, 5'd0, 32'h0);
        check32("reset_illegal", {31'b0, illegal_out}, 32'd0);
        step("wr_x5", 32'h0000_0013, 0, 0, 0, 1, 5'd5, 32'hDEAD_BEEF);
        step("add_x6", 32'h0002_8333, 0, 0, 0, 0, 5'd0, 32'h0);
        check32("add_data1", data1_out, 32'hDEAD_BEEF);
        check32("add_aluop", {27'b0, alu_op_out}, 32'd0);
        check32("add_rd", {27'b0, rd_out}, 32'd6);
        check32("add_rw", {31'b0, reg_write_enable_out}, 32'd1);

        // Bypass and x0
        step("addi_bypass", 32'hFFF3_8093, 0, 0, 0, 1, 5'd7, 32'h1234_5678);
        check32("bypass_data1", data1_out, 32'h1234_5678);
        check32("addi_imm", imm_out, 32'hFFFF_FFFF);
        step("wr_x0", 32'h0000_0333, 0, 0, 0, 1, 5'd0, 32'h5);
        check32("x0_bypass", data1_out, 32'h0);
        step("rd_x0", 32'h0000_0333, 0, 0, 0, 0, 5'd0, 32'h0);
        check32("x0_read", data1_out, 32'h0);

        // Immediates
        step("beq", 32'hFE00_0CE3, 0, 0, 0, 0, 5'd0, 32'h0);
        check32("beq_imm", imm_out, 32'hFFFF_FFF8);
        check32("beq_br", {31'b0, branch_out}, 32'd1);
        check32("beq_alu", {27'b0, alu_op_out}, 32'd1);
        step("jal", 32'h0010_00EF, 0, 0, 0, 0, 5'd0, 32'h0);
        check32("jal_imm", imm_out, 32'h0000_0800);
        check32("jal_sel", {28'b0, jump_out, alu_src1_sel, alu_src2_sel}, 32'b1110);

        // M-extension and memory
        step("div", 32'h0220_C1B3, 0, 0, 0, 0, 5'd0, 32'h0);
        check32("div_alu", {27'b0, alu_op_out}, 32'd14);
        step("lw", 32'h00C1_2203, 0, 0, 0, 0, 5'd0, 32'h0);
        check32("lw_ctl", {30'b0, mem_read_out, mux3_select_out}, 32'b11);
        check32("lw_imm", imm_out, 32'd12);
        step("sw", 32'h0041_2623, 0, 0, 0, 0, 5'd0, 32'h0);
        check32("sw_ctl", {30'b0, mem_write_out, reg_write_enable_out}, 32'b10);

        // Stall holds for three cycles while the instruction changes
        step("pre_stall", 32'h0002_8333, 0, 0, 0, 0, 5'd0, 32'h0);
        step("stall1", 32'hFFF3_8093, 1, 0, 0, 1, 5'd9, 32'h0000_0099);
        step("stall2", 32'h0220_C1B3, 1, 0, 0, 0, 5'd0, 32'h0);
        step("stall3", 32'hFFFF_FFFF, 1, 0, 0, 0, 5'd0, 32'h0);
        check32("stall_rd", {27'b0, rd_out}, 32'd6);
        check32("stall_data1", data1_out, 32'hDEAD_BEEF);
        // Write during stall must have landed in x9
        step("rd_x9", 32'h0004_8333, 0, 0, 0, 0, 5'd0, 32'h0);
        check32("stall_wb", data1_out, 32'h0000_0099);
        step("stall_flush", 32'h0220_C1B3, 1, 1, 0, 0, 5'd0, 32'h0);
        check32("flush_pc", pc_out, 32'h0);
        check32("flush_rw", {31'b0, reg_write_enable_out}, 32'd0);

        // Illegal encodings
        step("illegal_ones", 32'hFFFF_FFFF, 0, 0, 0, 0, 5'd0, 32'h0);
        check32("illegal_flag", {31'b0, illegal_out}, 32'd1);
        check32("illegal_ctl", {18'b0, alu_op_out, alu_src1_sel, alu_src2_sel,
                                mem_read_out, mem_write_out, mux3_select_out,
                                reg_write_enable_out, branch_out, jump_out}, 32'd0);
        step("illegal_f7", 32'h8000_0033, 0, 0, 0, 0, 5'd0, 32'h0);
        check32("illegal_f7_flag", {31'b0, illegal_out}, 32'd1);

        // Reset mid-stream drops the pending write and clears registers
        step("reset_mid", 32'h0000_0013, 0, 0, 1, 1, 5'd9, 32'hAAAA_5555);
        step("after_reset", 32'h0004_8333, 0, 0, 0, 0, 5'd0, 32'h0);
        check32("reset_clears", data1_out, 32'h0);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            ins = $urandom;
            if ($urandom_range(0, 9) != 0) ins[6:0] = valid_ops[$urandom_range(0, 8)];
            if (ins[6:0] == 7'b0110011 && $urandom_range(0, 3) != 0) begin
                case ($urandom_range(0, 2))
                    0:       ins[31:25] = 7'h00;
                    1:       ins[31:25] = 7'h20;
                    default: ins[31:25] = 7'h01;
                endcase
            end
            wr = 5'($urandom);
            if ($urandom_range(0, 3) == 0) wr = ins[19:15];
            if ($urandom_range(0, 7) == 0) cur_pc = $urandom & 32'hFFFF_FFFC;
            step("random", ins, ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 49) == 0), 1'($urandom), wr, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
